// File: rtl/cl_serial_subtractor.sv
// Digit-serial a - b over DATA_WIDTH bits, one DIGIT_WIDTH digit per clock.
// Integer mode ripples a registered borrow; GF(2) mode reduces to a XOR b.
module cl_serial_subtractor #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_option,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  bo
);

  localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The MSB of the widened result is the borrow out; forced low in GF mode.
  function automatic logic [DIGIT_WIDTH:0] digit_sub(
    input logic [DIGIT_WIDTH-1:0] x,
    input logic [DIGIT_WIDTH-1:0] y,
    input logic                   bin,
    input logic                   int_mode
  );
    logic [DIGIT_WIDTH:0] r;
    if (int_mode) begin
      r = {1'b0, x} - {1'b0, y} - {{DIGIT_WIDTH{1'b0}}, bin};
    end else begin
      r = {1'b0, x ^ y};
    end
    return r;
  endfunction

  state_t                  state_r, state_s;
  logic [CW-1:0]           cnt_r;
  logic                    borrow_r;
  logic                    mode_r;
  logic [DATA_WIDTH-1:0]   a_r, b_r, diff_r;
  logic                    bo_r, out_valid_r;
  logic [31:0]             base_s;
  logic                    last_s;
  logic [DIGIT_WIDTH:0]    dres_s;

  assign base_s = 32'(cnt_r) * 32'(DIGIT_WIDTH);
  assign last_s = (cnt_r == LAST_DIGIT);
  assign dres_s = digit_sub(a_r[base_s +: DIGIT_WIDTH], b_r[base_s +: DIGIT_WIDTH],
                            borrow_r, mode_r);

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bo        = bo_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (last_s) state_s = DONE;
        else        state_s = CALC;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, per-digit subtract and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      borrow_r    <= 1'b0;
      mode_r      <= 1'b0;
      a_r         <= {DATA_WIDTH{1'b0}};
      b_r         <= {DATA_WIDTH{1'b0}};
      diff_r      <= {DATA_WIDTH{1'b0}};
      bo_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            mode_r   <= carry_option;
            cnt_r    <= {CW{1'b0}};
            borrow_r <= 1'b0;
          end
        end
        CALC: begin
          diff_r[base_s +: DIGIT_WIDTH] <= dres_s[DIGIT_WIDTH-1:0];
          borrow_r <= dres_s[DIGIT_WIDTH];
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            bo_r        <= dres_s[DIGIT_WIDTH];
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_serial_subtractor.sv
// Directed bench for cl_serial_subtractor: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_cl_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        carry_option = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        bo;

  int errors = 0;
  int checks = 0;

  cl_serial_subtractor #(.DATA_WIDTH(32), .DIGIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_option(carry_option), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .bo(bo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic co);
    a = av; b = bv; carry_option = co; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (diff !== 32'h0) begin errors++; $display("FAIL reset_diff: got %h want 00000000", diff); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL reset_bo: got %b want 0", bo); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_int_basic();
    int n;
    start_op(32'h00000005, 32'h00000003, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: in_ready got %b want 0", in_ready); end
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", n); end
    checks++; if (diff !== 32'h00000002) begin errors++; $display("FAIL basic_diff: got %h want 00000002", diff); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_bo: got %b want 0", bo); end
    finish_op();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_ripple();
    int n;
    start_op(32'h00000000, 32'h00000001, 1'b1);
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL ripple_latency: got %0d want 4", n); end
    checks++; if (diff !== 32'hFFFFFFFF) begin errors++; $display("FAIL ripple_diff: got %h want FFFFFFFF", diff); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL ripple_bo: got %b want 1", bo); end
    finish_op();
  endtask

  task automatic test_mode_contrast();
    int n;
    start_op(32'hFFFF0000, 32'h0F0F0F0F, 1'b0);
    wait_valid(n);
    checks++; if (diff !== 32'hF0F00F0F) begin errors++; $display("FAIL gf_diff: got %h want F0F00F0F", diff); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL gf_bo: got %b want 0", bo); end
    finish_op();
    start_op(32'hFFFF0000, 32'h0F0F0F0F, 1'b1);
    wait_valid(n);
    checks++; if (diff !== 32'hF0EFF0F1) begin errors++; $display("FAIL int_diff: got %h want F0EFF0F1", diff); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL int_bo: got %b want 0", bo); end
    finish_op();
    start_op(32'h00000000, 32'hFFFFFFFF, 1'b0);
    wait_valid(n);
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL gf_bo_suppressed: got %b want 0", bo); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int n;
    start_op(32'h12345678, 32'h87654321, 1'b1);
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", n); end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 32'h00000001; b = 32'h00000001; carry_option = 1'b0; in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (diff !== 32'h8ACF1357) begin errors++; $display("FAIL bp_diff[%0d]: got %h want 8ACF1357", i, diff); end
      checks++; if (bo !== 1'b1) begin errors++; $display("FAIL bp_bo[%0d]: got %b want 1", i, bo); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    finish_op();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_capture: in_ready got %b want 1", in_ready); end
    checks++; if (diff !== 32'h8ACF1357) begin errors++; $display("FAIL bp_diff_held: got %h want 8ACF1357", diff); end
  endtask

  task automatic test_operand_stability();
    start_op(32'h00000100, 32'h00000001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; carry_option = i[0];
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stab_valid: got %b want 1", out_valid); end
    checks++; if (diff !== 32'h000000FF) begin errors++; $display("FAIL stab_diff: got %h want 000000FF", diff); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL stab_bo: got %b want 0", bo); end
    finish_op();
  endtask

  task automatic test_reset_mid_calc();
    int n;
    start_op(32'h00000000, 32'h00000001, 1'b1);
    tick(); tick(); tick();
    checks++; if (diff !== 32'h00FFFFFF) begin errors++; $display("FAIL partial_diff: got %h want 00FFFFFF", diff); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    checks++; if (diff !== 32'h0) begin errors++; $display("FAIL midrst_diff: got %h want 00000000", diff); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL midrst_bo: got %b want 0", bo); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL postrst_no_pulse: got %b want 0", out_valid); end
    start_op(32'h00000010, 32'h00000020, 1'b1);
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL postrst_latency: got %0d want 4", n); end
    checks++; if (diff !== 32'hFFFFFFF0) begin errors++; $display("FAIL postrst_diff: got %h want FFFFFFF0", diff); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL postrst_bo: got %b want 1", bo); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_int_basic();
    test_ripple();
    test_mode_contrast();
    test_backpressure();
    test_operand_stability();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cl_serial_subtractor.md
# cl_serial_subtractor

Digit-serial subtractor with a field select, computing a − b over DATA_WIDTH bits one DIGIT_WIDTH digit per clock. It is the inverse-operation companion to the combinational field-selectable adder. In integer mode the borrow ripples between digits through a registered borrow flag. In GF(2) mode borrow is suppressed, so the result is a XOR b. It sits behind a valid/ready handshake on both sides so it can be dropped into sequential GF/integer datapaths.

## Interface
- DATA_WIDTH, 32, operand and result width; must be an integer multiple of DIGIT_WIDTH.
- DIGIT_WIDTH, 8, bits processed per clock; NUM_DIGITS = DATA_WIDTH/DIGIT_WIDTH (≥1).
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts operands; high only in IDLE.
- a  input  DATA_WIDTH  minuend.
- b  input  DATA_WIDTH  subtrahend.
- carry_option  input  1  1 = integer subtract with borrow chain; 0 = GF(2) subtract (XOR, borrow forced 0).
- out_valid  output  1  diff/bo valid.
- out_ready  input  1  consumer accepts result.
- diff  output  DATA_WIDTH  result register.
- bo  output  1  borrow out of MSB digit (integer mode); 0 in GF mode.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, digit counter 0, borrow 0, diff 0, bo 0, out_valid 0. in_ready = (state==IDLE), so it is 1 while in reset.
- IDLE: on in_valid & in_ready, register a, b, carry_option. Clear counter and borrow. Go to CALC.
- CALC, digit k = counter (LSB digit first):
  - Integer mode: {br, d} = a[k] − b[k] − borrow, computed at DIGIT_WIDTH+1 bits. diff digit k ← d. borrow ← br.
  - GF mode: diff digit k ← a[k] ^ b[k]. borrow ← 0.
  - Counter increments each cycle. At k = NUM_DIGITS−1, load bo from the final borrow (0 in GF mode) and go to DONE.
- DONE: out_valid=1. diff and bo are held stable until out_ready=1, then go to IDLE with out_valid deasserted on that edge.
- Integer result: diff = (a − b) mod 2^DATA_WIDTH. bo = 1 iff a < b (unsigned).
- diff digits not yet written in CALC keep their previous contents. Observers use diff only when out_valid=1.
- a, b and carry_option are sampled only at accept. Changes during CALC/DONE have no effect.
- in_valid during CALC/DONE is ignored. No operand is captured and nothing is queued.
- Reset mid-CALC or mid-DONE aborts immediately: no out_valid pulse, all outputs return to their reset values.

## Timing
- Accept on edge T (in_valid & in_ready). CALC occupies edges T+1..T+NUM_DIGITS. out_valid rises after edge T+NUM_DIGITS.
- Latency: NUM_DIGITS cycles from accept to out_valid (4 for the defaults).
- Handshake completes on the edge where out_valid & out_ready. DONE→IDLE costs one cycle. Next accept is no earlier than the following edge.
- Minimum initiation interval is NUM_DIGITS+2 cycles (6 for the defaults).
- out_ready high before out_valid has no effect.
- All outputs except in_ready are registered. in_ready is a decode of the state register only.
- Defaults with NUM_DIGITS=1 degenerate to a single CALC cycle. The same rules apply.

## Test plan
- Integer basic: a=0x00000005, b=0x00000003, carry_option=1 → diff=0x00000002, bo=0. out_valid exactly 4 cycles after accept.
- Full borrow ripple: a=0x00000000, b=0x00000001, carry_option=1 → diff=0xFFFFFFFF, bo=1.
- Mode contrast, a=0xFFFF0000, b=0x0F0F0F0F:
  - carry_option=0 → diff=0xF0F00F0F, bo=0.
  - carry_option=1 → diff=0xF0EFF0F1, bo=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → diff, bo and out_valid remain stable and in_ready stays 0. A pulsed in_valid with new operands is not captured. Then out_ready=1 → IDLE next cycle.
- Operand stability: change a, b and carry_option every cycle during CALC → result matches the values sampled at accept.
- Reset mid-CALC (after digit 2): assert rst → out_valid=0, diff=0, bo=0 and in_ready=1 during reset. After release, a=0x00000010, b=0x00000020, carry_option=1 → diff=0xFFFFFFF0, bo=1.
